// File: rtl/execute_pipe.sv
// WISC execute stage: ALU, set-conditions, branch resolution and EX/MEM output register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (op 14); otherwise MUL yields 0.
module execute_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic [3:0]       in_op,
    input  logic [2:0]       in_br,
    input  logic [WIDTH-1:0] in_pc_inc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             flush,
    input  logic             out_stall,
    output logic             out_valid,
    output logic [15:0]      out_instr,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_next_pc,
    output logic             out_redirect,
    output logic             busy
);

    localparam logic [3:0] OpAdd = 4'd0,  OpSub = 4'd1,  OpXor  = 4'd2,  OpAndn  = 4'd3;
    localparam logic [3:0] OpRol = 4'd4,  OpSll = 4'd5,  OpRor  = 4'd6,  OpSrl   = 4'd7;
    localparam logic [3:0] OpSeq = 4'd8,  OpSlt = 4'd9,  OpSle  = 4'd10, OpSco   = 4'd11;
    localparam logic [3:0] OpBtr = 4'd12, OpPassb = 4'd13, OpMul = 4'd14, OpAnd = 4'd15;

    localparam logic [2:0] BrBeqz = 3'd1, BrBnez = 3'd2, BrBltz = 3'd3, BrBgez = 3'd4;
    localparam logic [2:0] BrJ    = 3'd5, BrJr   = 3'd6;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   btr;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] dbl_l, dbl_r;
    logic [WIDTH:0]     sum_c;
    logic               taken;
    logic [WIDTH-1:0]   target, next_pc;

    logic               out_valid_q, taken_q;
    logic [15:0]        instr_q;
    logic [WIDTH-1:0]   result_q, next_pc_q;
    logic               out_free, accept, load_alu;

    always_comb begin
        sh    = in_b[SHW-1:0];
        // Rotates come from the doubled operand so a zero amount needs no special case
        dbl_l = {in_a, in_a} << sh;
        dbl_r = {in_a, in_a} >> sh;
        sum_c = {1'b0, in_a} + {1'b0, in_b};
        btr   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            btr[i] = in_a[WIDTH-1-i];
        end
        case (in_op)
            OpAdd:   alu_res = sum_c[WIDTH-1:0];
            OpSub:   alu_res = in_b - in_a;
            OpXor:   alu_res = in_a ^ in_b;
            OpAndn:  alu_res = in_a & ~in_b;
            OpRol:   alu_res = dbl_l[2*WIDTH-1:WIDTH];
            OpSll:   alu_res = in_a << sh;
            OpRor:   alu_res = dbl_r[WIDTH-1:0];
            OpSrl:   alu_res = in_a >> sh;
            OpSeq:   alu_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OpSle:   alu_res = {{(WIDTH-1){1'b0}}, $signed(in_a) <= $signed(in_b)};
            OpSco:   alu_res = {{(WIDTH-1){1'b0}}, sum_c[WIDTH]};
            OpBtr:   alu_res = btr;
            OpPassb: alu_res = in_b;
            OpAnd:   alu_res = in_a & in_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (in_br)
            BrBeqz:      taken = (in_a == '0);
            BrBnez:      taken = (in_a != '0);
            BrBltz:      taken = in_a[WIDTH-1];
            BrBgez:      taken = ~in_a[WIDTH-1];
            BrJ, BrJr:   taken = 1'b1;
            default:     taken = 1'b0;
        endcase
        target  = (in_br == BrJr) ? (in_a + in_imm) : (in_pc_inc + in_imm);
        next_pc = taken ? target : in_pc_inc;
    end

    assign out_free = ~out_valid_q | ~out_stall;
    assign accept   = in_valid & in_ready;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [15:0]      pend_instr_q;
    logic [WIDTH-1:0] pend_next_pc_q;
    logic             pend_taken_q;
    logic             is_mul, load_mul;

    assign is_mul   = (in_op == OpMul);
    assign in_ready = (state_q == StIdle) & out_free & ~flush;
    assign load_alu = accept & ~is_mul;
    assign load_mul = (state_q == StDone) & out_free & ~flush;
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && is_mul) state_d = StMul;
            StMul:   if (cnt_q == SHW'(WIDTH - 1)) state_d = StDone;
            StDone:  if (out_free) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    // Partial product 0 is formed on acceptance, so StMul covers iterations 1..WIDTH-1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            pend_instr_q   <= '0;
            pend_next_pc_q <= '0;
            pend_taken_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && is_mul) begin
                acc_q          <= in_b[0] ? in_a : '0;
                mcand_q        <= in_a << 1;
                mplier_q       <= in_b >> 1;
                cnt_q          <= SHW'(1);
                pend_instr_q   <= in_instr;
                pend_next_pc_q <= next_pc;
                pend_taken_q   <= taken;
            end else if (state_q == StMul) begin
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SHW'(1);
            end
        end
    end
`else
    logic load_mul;

    assign in_ready = out_free & ~flush;
    assign load_alu = accept;
    assign load_mul = 1'b0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            result_q    <= '0;
            next_pc_q   <= '0;
            taken_q     <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            instr_q     <= in_instr;
            result_q    <= alu_res;
            next_pc_q   <= next_pc;
            taken_q     <= taken;
`ifdef EXEC_MUL_EN
        end else if (load_mul) begin
            out_valid_q <= 1'b1;
            instr_q     <= pend_instr_q;
            result_q    <= acc_q;
            next_pc_q   <= pend_next_pc_q;
            taken_q     <= pend_taken_q;
`endif
        end else if (!out_stall) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = instr_q;
    assign out_result   = result_q;
    assign out_next_pc  = next_pc_q;
    assign out_redirect = out_valid_q & taken_q;

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised, pipelined execute stage for the WISC core. It takes one pre-decoded instruction per handshake from the ID/EX boundary and computes the ALU result, set-condition result, branch decision and next PC. The outcome is held in an internal EX/MEM output register with valid/stall flow control. An optional iterative multiplier makes the stage multi-cycle and back-pressures decode while it runs.

## Interface
- WIDTH, 16, datapath width; must be a power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts; transfer occurs when in_valid & in_ready
- in_instr  in  16  raw instruction, passed through unchanged
- in_op  in  4  ALU op: 0 ADD, 1 SUB, 2 XOR, 3 ANDN, 4 ROL, 5 SLL, 6 ROR, 7 SRL, 8 SEQ, 9 SLT, 10 SLE, 11 SCO, 12 BTR, 13 PASSB, 14 MUL, 15 AND
- in_br  in  3  branch type: 0 none, 1 BEQZ, 2 BNEZ, 3 BLTZ, 4 BGEZ, 5 J, 6 JR, 7 none
- in_pc_inc  in  WIDTH  PC + 2
- in_a  in  WIDTH  Rs operand
- in_b  in  WIDTH  B operand, already selected and extended by decode
- in_imm  in  WIDTH  sign-extended branch/jump immediate
- flush  in  1  kill in-flight and registered work
- out_stall  in  1  downstream cannot take the output register
- out_valid  out  1  output register holds a valid instruction
- out_instr  out  16  registered instruction
- out_result  out  WIDTH  registered result
- out_next_pc  out  WIDTH  registered next PC
- out_redirect  out  1  out_valid & branch taken
- busy  out  1  multiplier in progress

## Operation
- ADD: a+b.
- SUB: b−a.
- XOR, AND.
- ANDN: a & ~b.
- Shifts and rotates: operate on a by b[SHW-1:0]. SRL is logical. ROR and ROL wrap.
- SEQ: a==b.
- SLT/SLE: signed a<b / a≤b. Must be exact at overflow (e.g. 0x8000 < 0x7FFF is true).
- SCO: carry-out of unsigned a+b.
- Set results are zero-extended to WIDTH.
- BTR: bit-reverse of a.
- PASSB: b.
- MUL: low WIDTH bits of a*b, unsigned. Computed by shift-add at one bit per cycle.
- Branch condition is evaluated on in_a against zero:
  - BEQZ: a==0.
  - BNEZ: a!=0.
  - BLTZ: a[WIDTH-1].
  - BGEZ: !a[WIDTH-1].
  - J and JR: always taken.
- Branch target:
  - JR: a + imm.
  - All other branch types: pc_inc + imm.
- out_next_pc = taken ? target : pc_inc. All additions wrap modulo 2^WIDTH.
- FSM states:
  - IDLE: an accepted non-MUL instruction loads the output register. An accepted MUL latches its operands and goes to MUL.
  - MUL: the counter runs 0..WIDTH-1, one partial product per cycle. After the last iteration go to DONE.
  - DONE: load the output register once it is free (!out_valid | !out_stall), then go to IDLE.
- in_ready = (state==IDLE) & (!out_valid | !out_stall) & !flush.
- busy = 1 in MUL and in DONE.
- flush:
  - Clears out_valid.
  - Returns the FSM to IDLE.
  - Nothing is accepted that cycle.
  - The killed instruction produces no redirect.

## Timing
- Reset values: all output-register fields 0, out_valid 0, out_redirect 0, busy 0, FSM in IDLE. in_ready is 1 the first cycle after reset is released.
- Single-cycle ops: accepted in cycle N, out_valid in N+1.
- MUL: accepted in N, busy from N+1, out_valid in N+WIDTH+1 if not stalled. Each stalled cycle while in DONE adds one cycle.
- While out_valid & out_stall, every output field holds stable.
- If the output is consumed and a new instruction is accepted in the same cycle, the register reloads with no bubble (full throughput).
- flush has priority over out_stall and over acceptance.
- rst mid-MUL aborts the multiply with no output.

## Configuration
- EXEC_MUL_EN defined: MUL is implemented as above.
- EXEC_MUL_EN undefined:
  - The multiplier datapath, MUL state and DONE state are removed.
  - in_op 14 completes in a single cycle with out_result = 0.
  - busy is tied to 0.

## Test plan
- Reset, then ADD a=0x7FFF b=0x0001 → out_valid next cycle, out_result 0x8000, out_next_pc = pc_inc.
- SLT a=0x8000 b=0x7FFF → 0x0001. SCO a=0xFFFF b=0x0001 → 0x0001. ROR a=0x0001 b=1 → 0x8000.
- BLTZ a=0xFFFE, pc_inc=0x0010, imm=0xFFF8 → out_redirect 1, out_next_pc 0x0008. Same with a=0x0002 → redirect 0, next_pc 0x0010.
- Back-to-back ADDs with out_stall held high for 3 cycles → in_ready 0 and outputs stable during the stall. No instruction lost or duplicated after release.
- With EXEC_MUL_EN, MUL a=0x0013 b=0x0021 → busy for 16 cycles, out_result 0x0273 in cycle N+17. Without the macro → result 0 in N+1.
- JR accepted, then flush asserted with out_stall high → out_valid 0 and no redirect. flush during MUL → busy drops next cycle and no output appears.
